pixel_packer: RTL and testbench
===============================

Name: pixel_packer

Overview:
- Consumes the per-pixel shade stream leaving the ray-march pipeline: shade, valid, sof (first pixel of frame), eol (last pixel of line).
- Packs PIX_PER_BEAT consecutive pixels into one beat and buffers beats in a FIFO.
- Presents the beats as an AXI4-Stream video master (tuser = start of frame, tlast = end of line) for the VDMA.
- The upstream pipeline cannot be stalled, so the FIFO absorbs downstream backpressure and reports any loss through sticky error flags.

Parameters:
- COLOR_W, default `COLOR_WIDTH (24): bits per pixel.
- PIX_PER_BEAT, default 2: pixels packed per output beat; must be ≥1.
- FIFO_DEPTH, default 16: beats of buffering; power of two.
- LVL_W, default $clog2(FIFO_DEPTH)+1: width of the level output.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- shade_in  in  COLOR_W  pixel colour, sampled when valid_in=1.
- valid_in  in  1  pixel strobe; there is no ready, so every strobe must be taken.
- sof_in  in  1  qualifies the pixel as the first of a frame.
- eol_in  in  1  qualifies the pixel as the last of a line.
- m_tdata  out  COLOR_W*PIX_PER_BEAT  packed beat; pixel 0 in the LSBs.
- m_tvalid  out  1  beat available.
- m_tready  in  1  downstream accept.
- m_tuser  out  1  beat starts a frame.
- m_tlast  out  1  beat ends a line.
- fifo_level  out  LVL_W  beats currently held in the FIFO.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.
- align_err  out  1  sticky: sof or eol arrived at a position not aligned to a beat boundary.

Behaviour:
- Reset values: all outputs 0, FIFO empty, pack index 0, pack register 0. Reset mid-operation discards the partial beat and all FIFO contents the same cycle, and clears both sticky flags.
- Pack state machine, states COLLECT and FLUSH_PAD:
  - COLLECT: on each valid_in, write the pixel into slot idx; idx increments.
  - The beat's tuser is set if sof_in arrives on slot 0.
  - The beat completes when idx==PIX_PER_BEAT-1 (tlast=eol_in), or when eol_in arrives earlier.
  - Early eol goes to FLUSH_PAD for one cycle: remaining slots are zero-padded, tlast=1, align_err set, the beat is pushed, and the state returns to COLLECT with idx=0.
  - A valid_in arriving during FLUSH_PAD is accepted into slot 0 of the next beat, so no pixel is lost.
- sof_in on slot ≠0: the partial beat is discarded, align_err is set, and the pixel is stored as slot 0 of a new beat with tuser=1.
- Beat push: a completed beat is written to the FIFO on the clock edge after the final pixel is sampled.
  - The write is accepted if fifo_level<FIFO_DEPTH, or if a pop occurs the same cycle (a simultaneous read and write when full is legal and the level is unchanged).
  - Otherwise the beat is dropped and overflow is set (sticky).
- FIFO output is first-word-fall-through: m_tvalid rises the cycle after the write into an empty FIFO. Pixel sampled at cycle N completing the beat → m_tvalid=1 at N+1.
- AXI-S rules:
  - Pop occurs when m_tvalid && m_tready.
  - m_tdata, m_tuser and m_tlast are held stable while m_tvalid && !m_tready.
  - m_tvalid never drops without a pop.
- fifo_level: +1 on push only, −1 on pop only, unchanged on both or neither. Read and write pointers wrap modulo FIFO_DEPTH.
- Throughput: one beat per cycle sustained with m_tready=1. Input rate is at most one pixel per cycle, so output demand is at most 1/PIX_PER_BEAT of cycles.
- Case PIX_PER_BEAT=1: every pixel is a beat, FLUSH_PAD is unreachable, and align_err can only be set by reset-free misuse (it never sets).

Test Plan:
- Aligned line, PIX_PER_BEAT=2, m_tready=1: pixels 0x000001..0x000004 with sof on the 1st and eol on the 4th → two beats, 0x000002000001 (tuser=1, tlast=0) and 0x000004000003 (tuser=0, tlast=1); first m_tvalid one cycle after pixel 2.
- Odd line of 3 pixels A,B,C with eol on C, immediately followed by a valid pixel D → beats {B,A} then {0,C} with tlast=1, align_err=1; D lands in slot 0 of the next beat.
- Backpressure: m_tready=0 while 40 pixels stream with FIFO_DEPTH=16 → fifo_level saturates at 16, the 17th–20th beats are dropped, overflow=1, and the held m_tdata stays unchanged. Raising m_tready then drains 16 beats in order.
- Full with simultaneous pop: FIFO at 16, m_tready=1 in the same cycle a beat completes → write accepted, level stays 16, overflow stays 0.
- sof on slot 1: sequence X, then Y with sof → X discarded, align_err=1, first output beat has tuser=1 with Y in the LSBs.
- Reset asserted with 5 beats queued and a partial beat in progress → the next cycle shows m_tvalid=0, fifo_level=0, flags cleared; the next aligned line packs correctly from slot 0.

Source files
------------

// File: rtl/pixel_packer.sv
// pixel_packer
//   Packs the per-pixel shade stream from the ray-march pipeline into
//   PIX_PER_BEAT-pixel beats, buffers them in a first-word-fall-through FIFO
//   and presents them as an AXI4-Stream video master (tuser = start of frame,
//   tlast = end of line). The upstream cannot be stalled, so any beat that
//   finds the FIFO full is dropped and reported through a sticky flag.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   shade_in    pixel colour, sampled when valid_in=1
//   valid_in    pixel strobe (no ready; every strobe is taken)
//   sof_in      pixel is the first of a frame
//   eol_in      pixel is the last of a line
//   m_tdata     packed beat, pixel 0 in the LSBs
//   m_tvalid    beat available
//   m_tready    downstream accept
//   m_tuser     beat starts a frame
//   m_tlast     beat ends a line
//   fifo_level  beats currently held in the FIFO
//   overflow    sticky: a completed beat was dropped on a full FIFO
//   align_err   sticky: sof/eol arrived off a beat boundary

`ifndef COLOR_WIDTH
`define COLOR_WIDTH 24
`endif

module pixel_packer #(
    parameter int COLOR_W      = `COLOR_WIDTH,
    parameter int PIX_PER_BEAT = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COLOR_W-1:0]                shade_in,
    input  logic                              valid_in,
    input  logic                              sof_in,
    input  logic                              eol_in,
    output logic [COLOR_W*PIX_PER_BEAT-1:0]   m_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tuser,
    output logic                              m_tlast,
    output logic [LVL_W-1:0]                  fifo_level,
    output logic                              overflow,
    output logic                              align_err
);

    localparam int BEAT_W  = COLOR_W * PIX_PER_BEAT;
    localparam int ENTRY_W = BEAT_W + 2;
    localparam int IDX_W   = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_BEAT - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        COLLECT   = 1'b0,
        FLUSH_PAD = 1'b1
    } state_t;

    // Insert one pixel into its slot of a beat; other slots are kept.
    function automatic logic [BEAT_W-1:0] put_slot(
        input logic [BEAT_W-1:0]  beat,
        input logic [IDX_W-1:0]   slot,
        input logic [COLOR_W-1:0] px
    );
        logic [BEAT_W-1:0] r;
        r = beat;
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            if (slot == IDX_W'(i)) begin
                r[i*COLOR_W +: COLOR_W] = px;
            end
        end
        return r;
    endfunction

    // Pointer advance with explicit wrap so any depth is handled.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     idx;
    logic [BEAT_W-1:0]    pack_data_p0;
    logic                 pack_user_p0;
    logic [BEAT_W-1:0]    flush_data_p1;
    logic                 flush_user_p1;

    logic [IDX_W-1:0]     eff_idx;
    logic                 misalign_sof;
    logic [BEAT_W-1:0]    base_data;
    logic                 base_user;
    logic [BEAT_W-1:0]    merged_data;
    logic                 merged_user;
    logic                 last_slot;
    logic                 beat_done;
    logic                 early_eol;

    logic                 push;
    logic [ENTRY_W-1:0]   push_entry;
    logic                 pop;
    logic                 wr_en;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ENTRY_W-1:0]   head;

    // ---- stage p0: slot placement of the incoming pixel ----
    // A sof always starts a fresh beat in slot 0; if it lands mid-beat the
    // partial beat collected so far is thrown away.
    always_comb begin
        eff_idx      = sof_in ? '0 : idx;
        misalign_sof = valid_in && sof_in && (idx != '0);
        base_data    = misalign_sof ? '0 : pack_data_p0;
        base_user    = misalign_sof ? 1'b0 : pack_user_p0;
        merged_data  = put_slot(base_data, eff_idx, shade_in);
        merged_user  = (eff_idx == '0) ? sof_in : base_user;
        last_slot    = (eff_idx == LAST_IDX);
        beat_done    = valid_in && last_slot;
        early_eol    = valid_in && eol_in && !last_slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // A padded beat is pushed from FLUSH_PAD one cycle after its early eol.
    // A pixel arriving meanwhile only ever fills slot 0, so it can never
    // complete a beat in the same cycle (PIX_PER_BEAT=1 never flushes).
    always_comb begin
        next_state = COLLECT;
        push       = 1'b0;
        push_entry = '0;
        if (early_eol) begin
            next_state = FLUSH_PAD;
        end
        if (state == FLUSH_PAD) begin
            push       = 1'b1;
            push_entry = {flush_user_p1, 1'b1, flush_data_p1};
        end else if (beat_done) begin
            push       = 1'b1;
            push_entry = {merged_user, eol_in, merged_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            pack_data_p0  <= '0;
            pack_user_p0  <= 1'b0;
            flush_data_p1 <= '0;
            flush_user_p1 <= 1'b0;
        end else if (valid_in) begin
            if (beat_done) begin
                idx          <= '0;
                pack_data_p0 <= '0;
                pack_user_p0 <= 1'b0;
            end else if (early_eol) begin
                flush_data_p1 <= merged_data;
                flush_user_p1 <= merged_user;
                idx           <= '0;
                pack_data_p0  <= '0;
                pack_user_p0  <= 1'b0;
            end else begin
                pack_data_p0 <= merged_data;
                pack_user_p0 <= merged_user;
                idx          <= eff_idx + IDX_W'(1);
            end
        end
    end

    // ---- stage p1: FIFO write / read ----
    // Writing into a full FIFO is legal only when the head leaves the same
    // cycle; the freed slot is the one the write pointer addresses.
    always_comb begin
        pop   = m_tvalid && m_tready;
        wr_en = push && ((fifo_level != FULL_LVL) || pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr_en && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (!wr_en && pop) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
            if ((state == FLUSH_PAD) || misalign_sof) begin
                align_err <= 1'b1;
            end
        end
    end

    // ---- output: fall-through head, forced to zero while empty ----
    always_comb begin
        head     = mem[rd_ptr];
        m_tvalid = (fifo_level != '0);
        m_tdata  = m_tvalid ? head[BEAT_W-1:0] : '0;
        m_tlast  = m_tvalid ? head[BEAT_W]     : 1'b0;
        m_tuser  = m_tvalid ? head[BEAT_W+1]   : 1'b0;
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer (COLOR_W=24, PIX_PER_BEAT=2, FIFO_DEPTH=16):
// a table of hand-computed vectors, hand-written multi-cycle corner cases,
// and a randomized run, all shadowed by a queue-based reference model.
module tb_pixel_packer;
    localparam int CW    = 24;
    localparam int PPB   = 2;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int BW    = CW * PPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          sof_in = 1'b0;
    logic          eol_in = 1'b0;
    logic          m_tready = 1'b0;
    logic [CW-1:0] shade_in = '0;
    logic [BW-1:0] m_tdata;
    logic          m_tvalid, m_tuser, m_tlast, overflow, align_err;
    logic [LW-1:0] fifo_level;

    pixel_packer #(
        .COLOR_W(CW), .PIX_PER_BEAT(PPB), .FIFO_DEPTH(DEPTH), .LVL_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .shade_in(shade_in), .valid_in(valid_in),
        .sof_in(sof_in), .eol_in(eol_in), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .fifo_level(fifo_level), .overflow(overflow),
        .align_err(align_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [BW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [CW-1:0] pix_q[$];
    logic          cur_user = 1'b0;
    bit            pend = 1'b0;
    beat_t         pend_beat;
    bit            m_ovf = 1'b0;
    bit            m_aerr = 1'b0;

    function automatic beat_t build(input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < pix_q.size(); i++)
            b.data = b.data | (BW'(pix_q[i]) << (i * CW));
        b.user = cur_user;
        b.last = last;
        return b;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic s, input logic e,
                              input logic [CW-1:0] px, input logic rdy);
        beat_t pushes[$];
        bit    do_pop;
        int    lvl;
        if (r) begin
            exp_q.delete();
            pix_q.delete();
            cur_user = 1'b0;
            pend     = 1'b0;
            m_ovf    = 1'b0;
            m_aerr   = 1'b0;
            return;
        end
        lvl    = exp_q.size();
        do_pop = (lvl > 0) && rdy;
        if (pend) begin
            pushes.push_back(pend_beat);
            pend   = 1'b0;
            m_aerr = 1'b1;
        end
        if (v) begin
            if (s && pix_q.size() != 0) begin
                pix_q.delete();
                m_aerr = 1'b1;
            end
            if (pix_q.size() == 0) cur_user = s;
            pix_q.push_back(px);
            if (pix_q.size() == PPB) begin
                pushes.push_back(build(e));
                pix_q.delete();
            end else if (e) begin
                pend_beat = build(1'b1);
                pend      = 1'b1;
                pix_q.delete();
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        foreach (pushes[k]) begin
            if (lvl < DEPTH || do_pop) exp_q.push_back(pushes[k]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_check();
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("align_err", 64'(align_err), 64'(m_aerr));
        if (exp_q.size() != 0) begin
            chk("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
            chk("m_tuser", 64'(m_tuser), 64'(exp_q[0].user));
            chk("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic e,
                        input logic [CW-1:0] px, input logic rdy);
        rst      = r;
        valid_in = v;
        sof_in   = s;
        eol_in   = e;
        shade_in = px;
        m_tready = rdy;
        @(posedge clk);
        model_edge(r, v, s, e, px, rdy);
        #1;
        model_check();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst, valid, sof, eol;
        logic [CW-1:0] shade;
        logic          rdy;
        logic          e_vld;
        logic [BW-1:0] e_data;
        logic          e_user, e_last;
        int            e_lvl;
        logic          e_ovf, e_aerr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [BW-1:0] ed;
        int            p;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        // aligned line
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000002, 1'b1, 1'b1, 48'h000002000001, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000003, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h000004, 1'b1, 1'b1, 48'h000004000003, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        // odd line A,B,C(eol) then D, E(eol)
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h00000A, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h00000B, 1'b1, 1'b1, 48'h00000B00000A, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h00000C, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h00000D, 1'b1, 1'b1, 48'h00000000000C, 1'b0, 1'b1, 1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h00000E, 1'b1, 1'b1, 48'h00000E00000D, 1'b0, 1'b1, 1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b1};
        // reset, then sof on slot 1
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h999999, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h111111, 1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h222222, 1'b1, 1'b1, 48'h222222111111, 1'b1, 1'b0, 1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 48'h0,            1'b0, 1'b0, 0, 1'b0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].sof, vecs[i].eol, vecs[i].shade, vecs[i].rdy);
            chk($sformatf("vec%0d_tvalid", i), 64'(m_tvalid), 64'(vecs[i].e_vld));
            chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].e_lvl));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_aerr", i), 64'(align_err), 64'(vecs[i].e_aerr));
            if (vecs[i].e_vld || vecs[i].rst) begin
                chk($sformatf("vec%0d_tdata", i), 64'(m_tdata), 64'(vecs[i].e_data));
                chk($sformatf("vec%0d_tuser", i), 64'(m_tuser), 64'(vecs[i].e_user));
                chk($sformatf("vec%0d_tlast", i), 64'(m_tlast), 64'(vecs[i].e_last));
            end
        end

        // ---- backpressure: 40 pixels with m_tready=0, then drain ----
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, (i == 0), 1'b0, 24'(i + 1), 1'b0);
            if (i == 31) begin
                chk("bp_level_at32", 64'(fifo_level), 64'd16);
                chk("bp_ovf_at32", 64'(overflow), 64'd0);
                chk("bp_hold_at32", 64'(m_tdata), 64'h000002000001);
            end
        end
        chk("bp_level", 64'(fifo_level), 64'd16);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_hold", 64'(m_tdata), 64'h000002000001);
        chk("bp_tuser", 64'(m_tuser), 64'd1);
        for (int j = 0; j < 16; j++) begin
            ed = {24'(2 * j + 2), 24'(2 * j + 1)};
            chk($sformatf("drain%0d", j), 64'(m_tdata), 64'(ed));
            step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        end
        chk("drain_empty", 64'(m_tvalid), 64'd0);
        chk("drain_level", 64'(fifo_level), 64'd0);

        // ---- full FIFO with simultaneous pop and push ----
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'(i + 1), 1'b0);
        chk("full_level", 64'(fifo_level), 64'd16);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'd34, 1'b1);
        chk("simul_level", 64'(fifo_level), 64'd16);
        chk("simul_ovf", 64'(overflow), 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        chk("simul_head", 64'(m_tdata), 64'h000004000003);
        chk("simul_ovf2", 64'(overflow), 64'd0);

        // ---- reset with 5 beats queued and a partial beat ----
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000A1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0000A2, 1'b0);
        for (int i = 3; i <= 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000A0 + 24'(i), 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        chk("pre_rst_aerr", 64'(align_err), 64'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_aerr", 64'(align_err), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 24'h0000B1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000B2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 24'h0000B3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h0000B4, 1'b0);
        chk("post_rst_level", 64'(fifo_level), 64'd2);
        chk("post_rst_b0", 64'(m_tdata), 64'h0000B20000B1);
        chk("post_rst_b0_user", 64'(m_tuser), 64'd1);
        chk("post_rst_b0_last", 64'(m_tlast), 64'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
        chk("post_rst_b1", 64'(m_tdata), 64'h0000B40000B3);
        chk("post_rst_b1_user", 64'(m_tuser), 64'd0);
        chk("post_rst_b1_last", 64'(m_tlast), 64'd1);

        // ---- randomized traffic against the model ----
        step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            case ((c / 500) % 4)
                0:       p = 1;
                1:       p = 5;
                2:       p = 9;
                default: p = 10;
            endcase
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 6) == 0),
                 24'($urandom),
                 ($urandom_range(0, 9) < p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
